// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: branch/jump resolution, forwarding,
// byte-lane data memory, and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int DMEM_DEPTH = 2048
) (
    input  logic        i_memory_clk,
    input  logic        i_memory_reset,
    input  logic [31:0] i_memory_pc,
    input  logic [31:0] i_memory_inst,
    input  logic        i_memory_insn_vld,
    input  logic        i_memory_ctrl,
    input  logic [31:0] i_memory_alu_data,
    input  logic [31:0] i_memory_rs2_data,
    input  logic        i_memory_br_equal,
    input  logic        i_memory_br_less,
    input  logic        i_memory_lsu_wren,
    input  logic [2:0]  i_memory_slt_sl,
    input  logic [1:0]  i_memory_wb_sel,
    input  logic        i_memory_rd_wren,
    output logic        o_memory_flush,
    output logic [31:0] o_memory_pc_target,
    output logic [31:0] o_memory_fwd_data,
    output logic [31:0] o_memory_pc_wb,
    output logic [31:0] o_memory_inst_wb,
    output logic [31:0] o_memory_alu_data_wb,
    output logic [31:0] o_memory_ld_data_wb,
    output logic [1:0]  o_memory_wb_sel_wb,
    output logic        o_memory_rd_wren_wb,
    output logic        o_memory_insn_vld_wb,
    output logic        o_memory_ctrl_wb
);
    localparam int          AW        = $clog2(DMEM_DEPTH);
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_jal, is_jalr, br_taken;
    logic [31:0] pc_plus4;

    assign opcode  = i_memory_inst[6:0];
    assign funct3  = i_memory_inst[14:12];
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    always_comb begin
        br_taken = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:         br_taken = i_memory_br_equal;
                3'b001:         br_taken = !i_memory_br_equal;
                3'b100, 3'b110: br_taken = i_memory_br_less;
                3'b101, 3'b111: br_taken = !i_memory_br_less;
                default:        br_taken = 1'b0;
            endcase
        end
    end

    assign o_memory_flush     = i_memory_insn_vld & (is_jal | is_jalr | br_taken);
    assign o_memory_pc_target = is_jalr ? {i_memory_alu_data[31:1], 1'b0} : i_memory_alu_data;
    assign pc_plus4           = i_memory_pc + 32'd4;
    assign o_memory_fwd_data  = (i_memory_wb_sel == 2'b10) ? pc_plus4 : i_memory_alu_data;

    // Word-organised memory with four byte lanes; upper address bits wrap.
    logic [3:0][7:0] dmem [DMEM_DEPTH];
    logic [AW-1:0]   idx;
    logic [1:0]      byte_sel;
    logic [3:0]      st_be;
    logic [3:0][7:0] st_data;
    logic            wr_en;

    assign idx      = i_memory_alu_data[AW+1:2];
    assign byte_sel = i_memory_alu_data[1:0];
    assign wr_en    = i_memory_lsu_wren & i_memory_insn_vld & !i_memory_reset;

    always_comb begin
        st_be   = 4'b0000;
        st_data = '0;
        case (i_memory_slt_sl)
            3'b000: begin
                st_be   = 4'b0001 << byte_sel;
                st_data = {4{i_memory_rs2_data[7:0]}};
            end
            3'b001: begin
                st_be   = i_memory_alu_data[1] ? 4'b1100 : 4'b0011;
                st_data = {2{i_memory_rs2_data[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = i_memory_rs2_data;
            end
        endcase
    end

    always_ff @(posedge i_memory_clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (st_be[l]) dmem[idx][l] <= st_data[l];
            end
        end
    end

    logic [3:0][7:0] rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    assign rd_word = dmem[idx];
    assign ld_byte = rd_word[byte_sel];
    assign ld_half = i_memory_alu_data[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

    always_comb begin
        case (i_memory_slt_sl)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge i_memory_clk) begin
        if (i_memory_reset) begin
            o_memory_pc_wb       <= '0;
            o_memory_inst_wb     <= INST_NOP;
            o_memory_alu_data_wb <= '0;
            o_memory_ld_data_wb  <= '0;
            o_memory_wb_sel_wb   <= 2'b00;
            o_memory_rd_wren_wb  <= 1'b0;
            o_memory_insn_vld_wb <= 1'b0;
            o_memory_ctrl_wb     <= 1'b0;
        end else begin
            o_memory_pc_wb       <= i_memory_pc;
            o_memory_inst_wb     <= i_memory_inst;
            o_memory_alu_data_wb <= i_memory_alu_data;
            o_memory_ld_data_wb  <= ld_data;
            o_memory_wb_sel_wb   <= i_memory_wb_sel;
            o_memory_rd_wren_wb  <= i_memory_rd_wren;
            o_memory_insn_vld_wb <= i_memory_insn_vld;
            o_memory_ctrl_wb     <= i_memory_ctrl;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory and branch rules.
module tb_memory_cycle;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, inst, alu, rs2;
    logic        vld, ctrl, eq, less, wren, rdw;
    logic [2:0]  f3;
    logic [1:0]  wbs;
    logic        flush;
    logic [31:0] target, fwd, pc_wb, inst_wb, alu_wb, ld_wb;
    logic [1:0]  wbs_wb;
    logic        rdw_wb, vld_wb, ctrl_wb;

    int n_tests = 0;
    int n_fail  = 0;
    bit [7:0] mb [DEPTH*4];

    always #5 clk = ~clk;

    memory_cycle #(.DMEM_DEPTH(DEPTH)) dut (
        .i_memory_clk(clk), .i_memory_reset(reset), .i_memory_pc(pc),
        .i_memory_inst(inst), .i_memory_insn_vld(vld), .i_memory_ctrl(ctrl),
        .i_memory_alu_data(alu), .i_memory_rs2_data(rs2),
        .i_memory_br_equal(eq), .i_memory_br_less(less),
        .i_memory_lsu_wren(wren), .i_memory_slt_sl(f3), .i_memory_wb_sel(wbs),
        .i_memory_rd_wren(rdw), .o_memory_flush(flush),
        .o_memory_pc_target(target), .o_memory_fwd_data(fwd),
        .o_memory_pc_wb(pc_wb), .o_memory_inst_wb(inst_wb),
        .o_memory_alu_data_wb(alu_wb), .o_memory_ld_data_wb(ld_wb),
        .o_memory_wb_sel_wb(wbs_wb), .o_memory_rd_wren_wb(rdw_wb),
        .o_memory_insn_vld_wb(vld_wb), .o_memory_ctrl_wb(ctrl_wb)
    );

    // Reference model: flat byte array, addresses wrap modulo memory size.
    function automatic int baddr(input logic [31:0] a);
        return int'(a & 32'(DEPTH*4-1));
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int b = baddr(a);
        if (sz == 3'b000) mb[b] = d[7:0];
        else if (sz == 3'b001) begin
            b = b & ~1;
            mb[b] = d[7:0]; mb[b+1] = d[15:8];
        end else begin
            b = b & ~3;
            for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz);
        int b = baddr(a);
        int h = b & ~1;
        int w = b & ~3;
        logic [7:0]  by = mb[b];
        logic [15:0] hw = {mb[h+1], mb[h]};
        case (sz)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'h0, by};
            3'b101:  return {16'h0, hw};
            default: return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
        endcase
    endfunction

    function automatic bit model_redirect(input logic [31:0] in, input logic e, input logic l, input logic v);
        bit t;
        case (in[6:0])
            7'b1101111, 7'b1100111: t = 1;
            7'b1100011: begin
                case (in[14:12])
                    3'd0: t = e;      3'd1: t = !e;
                    3'd4, 3'd6: t = l; 3'd5, 3'd7: t = !l;
                    default: t = 0;
                endcase
            end
            default: t = 0;
        endcase
        return t && v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        pc = 0; inst = 32'h13; vld = 0; ctrl = 0; alu = 0; rs2 = 0;
        eq = 0; less = 0; wren = 0; f3 = 0; wbs = 0; rdw = 0;
    endtask

    // One memory instruction for one cycle; returns at post-edge.
    task automatic mem_op(input bit st, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        idle();
        vld = 1; f3 = sz; alu = a; rs2 = d; wren = st;
        inst = st ? {17'h0, sz, 12'h023} : {17'h0, sz, 12'h003};
        wbs = st ? 2'b00 : 2'b01;
        tick();
        if (st) model_store(a, sz, d);
    endtask

    task automatic test_reset();
        mem_op(1, 3'b010, 32'h40, 32'h1122_3344);
        idle();
        reset = 1; vld = 1; wren = 1; f3 = 3'b010; alu = 32'h40; rs2 = 32'hFFFF_FFFF;
        pc = 32'h1234; inst = 32'h00A0_0093; rdw = 1; ctrl = 1; wbs = 2'b01;
        tick(); tick();
        n_tests++; if (inst_wb !== 32'h13) begin n_fail++; $display("FAIL reset_inst_wb got %h want 00000013", inst_wb); end
        n_tests++; if ({pc_wb, alu_wb, ld_wb} !== 96'h0) begin n_fail++; $display("FAIL reset_data_wb got %h %h %h want 0", pc_wb, alu_wb, ld_wb); end
        n_tests++; if ({wbs_wb, rdw_wb, vld_wb, ctrl_wb} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl_wb got %b want 00000", {wbs_wb, rdw_wb, vld_wb, ctrl_wb}); end
        reset = 0;
        mem_op(0, 3'b010, 32'h40, 0);
        n_tests++; if (ld_wb !== 32'h1122_3344) begin n_fail++; $display("FAIL reset_no_store got %h want 11223344", ld_wb); end
    endtask

    task automatic test_branch();
        idle();
        inst = 32'h0020_8463; alu = 32'h100; vld = 1; eq = 1; #1;
        n_tests++; if (flush !== 1'b1 || target !== 32'h100) begin n_fail++; $display("FAIL beq_taken got flush=%b tgt=%h want 1 00000100", flush, target); end
        eq = 0; #1;
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got %b want 0", flush); end
        eq = 1; vld = 0; #1;
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL beq_bubble got %b want 0", flush); end
        inst = 32'h0000_006F; #1;
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jal_bubble got %b want 0", flush); end
        tick();
    endtask

    task automatic test_jalr();
        idle();
        inst = 32'h0000_80E7; alu = 32'h203; pc = 32'h40; wbs = 2'b10; vld = 1; rdw = 1; #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jalr_flush got %b want 1", flush); end
        n_tests++; if (target !== 32'h202) begin n_fail++; $display("FAIL jalr_target got %h want 00000202", target); end
        n_tests++; if (fwd !== 32'h44) begin n_fail++; $display("FAIL jalr_fwd got %h want 00000044", fwd); end
        tick();
        n_tests++; if (alu_wb !== 32'h203 || pc_wb !== 32'h40) begin n_fail++; $display("FAIL jalr_wb got alu=%h pc=%h want 00000203 00000040", alu_wb, pc_wb); end
        n_tests++; if (wbs_wb !== 2'b10 || inst_wb !== 32'h0000_80E7) begin n_fail++; $display("FAIL jalr_wb_ctrl got %b %h want 10 000080e7", wbs_wb, inst_wb); end
    endtask

    task automatic test_store_load();
        mem_op(1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        mem_op(1, 3'b000, 32'h11, 32'hABCD_EF7F);
        mem_op(1, 3'b001, 32'h12, 32'h5555_8001);
        mem_op(0, 3'b010, 32'h10, 0);
        n_tests++; if (ld_wb !== 32'h8001_7FEF) begin n_fail++; $display("FAIL lw_merged got %h want 80017fef", ld_wb); end
        mem_op(0, 3'b000, 32'h13, 0);
        n_tests++; if (ld_wb !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb got %h want ffffff80", ld_wb); end
        mem_op(0, 3'b100, 32'h13, 0);
        n_tests++; if (ld_wb !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu got %h want 00000080", ld_wb); end
        mem_op(0, 3'b001, 32'h10, 0);
        n_tests++; if (ld_wb !== 32'h0000_7FEF) begin n_fail++; $display("FAIL lh got %h want 00007fef", ld_wb); end
        mem_op(0, 3'b101, 32'h12, 0);
        n_tests++; if (ld_wb !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu got %h want 00008001", ld_wb); end
    endtask

    task automatic test_back_to_back();
        mem_op(1, 3'b010, 32'h20, 32'h1234_5678);
        mem_op(0, 3'b010, 32'h20, 0);
        n_tests++; if (ld_wb !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_lw got %h want 12345678", ld_wb); end
    endtask

    task automatic test_wrap();
        mem_op(1, 3'b010, 32'h2000, 32'hA5A5_A5A5);
        mem_op(0, 3'b010, 32'h0, 0);
        n_tests++; if (ld_wb !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wrap_lw got %h want a5a5a5a5", ld_wb); end
    endtask

    task automatic test_random();
        logic [6:0]  ops [6] = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0110011};
        logic [31:0] e_pc, e_inst, e_alu, e_ld, e_fwd, e_tgt;
        logic [1:0]  e_wbs;
        logic        e_rdw, e_vld, e_ctrl, e_flush;
        for (int i = 0; i < 16; i++) mem_op(1, 3'b010, 32'(i*4), $urandom);
        for (int i = 0; i < 300; i++) begin
            idle();
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 5)];
            f3 = inst[14:12];
            pc = $urandom; rs2 = $urandom;
            alu = ($urandom & ~32'h1FFF) | ($urandom & 32'h3F);
            vld = ($urandom_range(0, 3) != 0);
            wren = (inst[6:0] == 7'b0100011 && f3 <= 3'b010) || ($urandom_range(0, 15) == 0);
            eq = $urandom; less = $urandom; wbs = $urandom; rdw = $urandom; ctrl = $urandom;
            e_flush = model_redirect(inst, eq, less, vld);
            e_tgt = (inst[6:0] == 7'b1100111) ? (alu & ~32'h1) : alu;
            e_fwd = (wbs == 2'b10) ? pc + 4 : alu;
            e_ld = model_load(alu, f3);
            e_pc = pc; e_inst = inst; e_alu = alu; e_wbs = wbs;
            e_rdw = rdw; e_vld = vld; e_ctrl = ctrl;
            #1;
            n_tests++; if (flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush[%0d] inst=%h got %b want %b", i, inst, flush, e_flush); end
            if (e_flush) begin
                n_tests++; if (target !== e_tgt) begin n_fail++; $display("FAIL rnd_target[%0d] got %h want %h", i, target, e_tgt); end
            end
            n_tests++; if (fwd !== e_fwd) begin n_fail++; $display("FAIL rnd_fwd[%0d] got %h want %h", i, fwd, e_fwd); end
            tick();
            if (wren && vld) model_store(e_alu, f3, rs2);
            n_tests++; if (ld_wb !== e_ld) begin n_fail++; $display("FAIL rnd_ld[%0d] sz=%b addr=%h got %h want %h", i, f3, e_alu, ld_wb, e_ld); end
            n_tests++; if (pc_wb !== e_pc || inst_wb !== e_inst || alu_wb !== e_alu) begin n_fail++; $display("FAIL rnd_wb_data[%0d] got %h %h %h want %h %h %h", i, pc_wb, inst_wb, alu_wb, e_pc, e_inst, e_alu); end
            n_tests++; if ({wbs_wb, rdw_wb, vld_wb, ctrl_wb} !== {e_wbs, e_rdw, e_vld, e_ctrl}) begin n_fail++; $display("FAIL rnd_wb_ctrl[%0d] got %b want %b", i, {wbs_wb, rdw_wb, vld_wb, ctrl_wb}, {e_wbs, e_rdw, e_vld, e_ctrl}); end
        end
        // Sweep the touched region so any silent corruption shows up.
        for (int i = 0; i < 16; i++) begin
            mem_op(0, 3'b010, 32'(i*4), 0);
            n_tests++; if (ld_wb !== model_load(32'(i*4), 3'b010)) begin n_fail++; $display("FAIL rnd_sweep[%0d] got %h want %h", i, ld_wb, model_load(32'(i*4), 3'b010)); end
        end
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        test_reset();
        test_branch();
        test_jalr();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
